// File: rtl/line_xfer_pkg.sv
// Shared types and constants for the cache line fill/writeback engine.
package line_xfer_pkg;

  localparam int SET_WIDTH      = 4;
  localparam int LINE_WIDTH     = 256;
  localparam int BEAT_WIDTH     = 64;
  localparam int NUM_BEATS      = LINE_WIDTH / BEAT_WIDTH;
  localparam int BEAT_IDX_WIDTH = 2;
  localparam int OFFSET_BITS    = 5;
  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MASK_WIDTH     = LINE_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FILL_BURST = 3'd1,
    ST_FILL_WRITE = 3'd2,
    ST_WB_READ    = 3'd3,
    ST_WB_WAIT    = 3'd4,
    ST_WB_BURST   = 3'd5,
    ST_DONE       = 3'd6
  } xfer_state_e;

  function automatic logic [MEM_ADDR_WIDTH-1:0] line_align(input logic [MEM_ADDR_WIDTH-1:0] addr);
    return addr & {{(MEM_ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/line_xfer_buffer.sv
// One-line staging register: beat-wise fill from memory, whole-line load from the
// array, and beat selection for streaming out.
module line_xfer_buffer
  import line_xfer_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      beat_we_i,
  input  logic [BEAT_IDX_WIDTH-1:0] beat_idx_i,
  input  logic [BEAT_WIDTH-1:0]     beat_din_i,
  input  logic                      line_we_i,
  input  logic [LINE_WIDTH-1:0]     line_din_i,
  output logic [LINE_WIDTH-1:0]     line_o,
  output logic [BEAT_WIDTH-1:0]     beat_o
);

  logic [LINE_WIDTH-1:0] line_q;

  // Line storage; a whole-line load takes priority over a beat write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= {LINE_WIDTH{1'b0}};
    end else if (line_we_i) begin
      line_q <= line_din_i;
    end else if (beat_we_i) begin
      line_q[beat_idx_i*BEAT_WIDTH +: BEAT_WIDTH] <= beat_din_i;
    end else begin
      line_q <= line_q;
    end
  end

  assign line_o = line_q;
  assign beat_o = line_q[beat_idx_i*BEAT_WIDTH +: BEAT_WIDTH];

endmodule

// File: rtl/line_transfer_engine.sv
// Fill/writeback engine between the cache data array and the burst memory port.
// Idle: the cache path owns the array through a mux; busy: the engine owns it.
module line_transfer_engine
  import line_xfer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_op,
  input  logic [SET_WIDTH-1:0]      req_set,
  input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
  output logic                      done,
  input  logic                      c_csb,
  input  logic                      c_web,
  input  logic [MASK_WIDTH-1:0]     c_wmask,
  input  logic [SET_WIDTH-1:0]      c_addr,
  input  logic [LINE_WIDTH-1:0]     c_din,
  output logic                      sram_csb,
  output logic                      sram_web,
  output logic [MASK_WIDTH-1:0]     sram_wmask,
  output logic [SET_WIDTH-1:0]      sram_addr,
  output logic [LINE_WIDTH-1:0]     sram_din,
  input  logic [LINE_WIDTH-1:0]     sram_dout,
  output logic [MEM_ADDR_WIDTH-1:0] bmem_addr,
  output logic                      bmem_read,
  output logic                      bmem_write,
  output logic [BEAT_WIDTH-1:0]     bmem_wdata,
  input  logic [BEAT_WIDTH-1:0]     bmem_rdata,
  input  logic                      bmem_resp
);

  localparam logic [BEAT_IDX_WIDTH-1:0] LAST_BEAT = BEAT_IDX_WIDTH'(NUM_BEATS - 1);

  xfer_state_e               state_q;
  logic [BEAT_IDX_WIDTH-1:0] cnt_q;
  logic [SET_WIDTH-1:0]      set_q;
  logic [MEM_ADDR_WIDTH-1:0] bmem_addr_q;
  logic                      req_ready_q;
  logic                      done_q;
  logic                      bmem_read_q;
  logic                      bmem_write_q;
  logic                      beat_we_s;
  logic                      line_we_s;
  logic [LINE_WIDTH-1:0]     line_s;

  assign beat_we_s = (state_q == ST_FILL_BURST) && bmem_resp;
  // The array drives dout on the negedge after the read, so WB_WAIT's closing edge captures it.
  assign line_we_s = (state_q == ST_WB_WAIT);

  line_xfer_buffer u_buffer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .beat_we_i  (beat_we_s),
    .beat_idx_i (cnt_q),
    .beat_din_i (bmem_rdata),
    .line_we_i  (line_we_s),
    .line_din_i (sram_dout),
    .line_o     (line_s),
    .beat_o     (bmem_wdata)
  );

  // Transfer sequencer with registered handshake and burst-command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {BEAT_IDX_WIDTH{1'b0}};
      set_q        <= {SET_WIDTH{1'b0}};
      bmem_addr_q  <= {MEM_ADDR_WIDTH{1'b0}};
      req_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            set_q       <= req_set;
            bmem_addr_q <= line_align(req_addr);
            cnt_q       <= {BEAT_IDX_WIDTH{1'b0}};
            req_ready_q <= 1'b0;
            if (req_op) begin
              state_q <= ST_WB_READ;
            end else begin
              state_q     <= ST_FILL_BURST;
              bmem_read_q <= 1'b1;
            end
          end
        end
        ST_FILL_BURST: begin
          if (bmem_resp) begin
            cnt_q <= cnt_q + BEAT_IDX_WIDTH'(1);
            if (cnt_q == LAST_BEAT) begin
              bmem_read_q <= 1'b0;
              state_q     <= ST_FILL_WRITE;
            end
          end
        end
        ST_FILL_WRITE: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_WB_READ: begin
          state_q <= ST_WB_WAIT;
        end
        ST_WB_WAIT: begin
          state_q      <= ST_WB_BURST;
          bmem_write_q <= 1'b1;
        end
        ST_WB_BURST: begin
          if (bmem_resp) begin
            cnt_q <= cnt_q + BEAT_IDX_WIDTH'(1);
            if (cnt_q == LAST_BEAT) begin
              bmem_write_q <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q      <= ST_IDLE;
          cnt_q        <= {BEAT_IDX_WIDTH{1'b0}};
          req_ready_q  <= 1'b1;
          done_q       <= 1'b0;
          bmem_read_q  <= 1'b0;
          bmem_write_q <= 1'b0;
        end
      endcase
    end
  end

  // Array port mux: cache path while idle, engine-driven accesses otherwise.
  always_comb begin
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_wmask = {MASK_WIDTH{1'b0}};
    sram_addr  = set_q;
    sram_din   = line_s;
    case (state_q)
      ST_IDLE: begin
        sram_csb   = c_csb;
        sram_web   = c_web;
        sram_wmask = c_wmask;
        sram_addr  = c_addr;
        sram_din   = c_din;
      end
      ST_FILL_WRITE: begin
        sram_csb   = 1'b0;
        sram_web   = 1'b0;
        sram_wmask = {MASK_WIDTH{1'b1}};
      end
      ST_WB_READ: begin
        sram_csb = 1'b0;
      end
      default: begin
        sram_csb = 1'b1;
      end
    endcase
  end

  assign req_ready  = req_ready_q;
  assign done       = done_q;
  assign bmem_addr  = bmem_addr_q;
  assign bmem_read  = bmem_read_q;
  assign bmem_write = bmem_write_q;

endmodule
